// File: rtl/riscv_decode_ctrl.sv
// RV32I decode and multi-cycle control FSM (IDLE/DECODE/EXEC/MEM/WB) driving the ALU and data memory.
// Optional macro FUNCT7_CHECK_EN rejects R-type / shift-immediate encodings with illegal funct7.
module riscv_decode_ctrl #(
    parameter int unsigned MEM_TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        inst_valid,
    output logic        inst_ready,
    input  logic [31:0] inst,
    input  logic        doBranch,
    input  logic        mem_ready,
    output logic [3:0]  ALUOp,
    output logic        ALUSrc,
    output logic [2:0]  funct3,
    output logic [6:0]  funct7,
    output logic [31:0] imm32,
    output logic [4:0]  rs1,
    output logic [4:0]  rs2,
    output logic [4:0]  rd,
    output logic        RegWrite,
    output logic        MemRead,
    output logic        MemWrite,
    output logic        MemtoReg,
    output logic [1:0]  pc_src,
    output logic        instr_done,
    output logic        err
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_DECODE = 3'd1;
    localparam logic [2:0] S_EXEC   = 3'd2;
    localparam logic [2:0] S_MEM    = 3'd3;
    localparam logic [2:0] S_WB     = 3'd4;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IARITH = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    localparam logic [15:0] TIMEOUT_L = 16'(MEM_TIMEOUT);

    logic [2:0]  r_state;
    logic        r_ready_en;
    logic [3:0]  r_aluop;
    logic        r_alusrc;
    logic [2:0]  r_funct3;
    logic [6:0]  r_funct7;
    logic [31:0] r_imm;
    logic [4:0]  r_rs1, r_rs2, r_rd;
    logic        r_load, r_store, r_branch, r_jal, r_jalr;
    logic        r_regwrite, r_illegal;
    logic [1:0]  r_pc_src;
    logic [15:0] r_cnt;
    logic        r_err;

    logic [6:0]  w_opcode;
    logic [2:0]  w_f3;
    logic [6:0]  w_f7;
    logic [31:0] w_imm_i, w_imm_s, w_imm_b, w_imm_j, w_imm_u;
    logic [3:0]  w_aluop;
    logic        w_alusrc;
    logic [31:0] w_imm;
    logic [4:0]  w_rs1, w_rs2, w_rd;
    logic        w_load, w_store, w_branch, w_jal, w_jalr, w_wr_class, w_illegal;
    logic [1:0]  w_pc_src_exec;
    logic [15:0] w_cnt_inc;
    logic        w_inst_ready;

    assign w_opcode = inst[6:0];
    assign w_f3     = inst[14:12];
    assign w_f7     = inst[31:25];
    assign w_imm_i  = {{20{inst[31]}}, inst[31:20]};
    assign w_imm_s  = {{20{inst[31]}}, inst[31:25], inst[11:7]};
    assign w_imm_b  = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
    assign w_imm_j  = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
    // U immediate stays unshifted; the ALU applies the <<12 itself.
    assign w_imm_u  = {12'd0, inst[31:12]};

    always_comb begin
        w_aluop    = 4'b1111;
        w_alusrc   = 1'b0;
        w_imm      = 32'd0;
        w_rs1      = inst[19:15];
        w_rs2      = inst[24:20];
        w_rd       = inst[11:7];
        w_load     = 1'b0;
        w_store    = 1'b0;
        w_branch   = 1'b0;
        w_jal      = 1'b0;
        w_jalr     = 1'b0;
        w_wr_class = 1'b0;
        w_illegal  = 1'b0;
        case (w_opcode)
            OP_R: begin
                w_aluop    = 4'b0010;
                w_wr_class = 1'b1;
`ifdef FUNCT7_CHECK_EN
                if (!((w_f7 == 7'h00) || ((w_f7 == 7'h20) && ((w_f3 == 3'd0) || (w_f3 == 3'd5)))))
                    w_illegal = 1'b1;
`endif
            end
            OP_IARITH: begin
                w_aluop    = 4'b0011;
                w_alusrc   = 1'b1;
                w_imm      = w_imm_i;
                w_rs2      = 5'd0;
                w_wr_class = 1'b1;
`ifdef FUNCT7_CHECK_EN
                if ((w_f3 == 3'd1) && (w_f7 != 7'h00))
                    w_illegal = 1'b1;
                if ((w_f3 == 3'd5) && (w_f7 != 7'h00) && (w_f7 != 7'h20))
                    w_illegal = 1'b1;
`endif
            end
            OP_LOAD: begin
                w_aluop    = 4'b0000;
                w_alusrc   = 1'b1;
                w_imm      = w_imm_i;
                w_rs2      = 5'd0;
                w_load     = 1'b1;
                w_wr_class = 1'b1;
            end
            OP_STORE: begin
                w_aluop  = 4'b0000;
                w_alusrc = 1'b1;
                w_imm    = w_imm_s;
                w_rd     = 5'd0;
                w_store  = 1'b1;
            end
            OP_BRANCH: begin
                w_aluop  = 4'b0001;
                w_imm    = w_imm_b;
                w_rd     = 5'd0;
                w_branch = 1'b1;
            end
            OP_JAL: begin
                w_aluop    = 4'b0100;
                w_imm      = w_imm_j;
                w_rs1      = 5'd0;
                w_rs2      = 5'd0;
                w_jal      = 1'b1;
                w_wr_class = 1'b1;
            end
            OP_JALR: begin
                w_aluop    = 4'b0100;
                w_imm      = w_imm_i;
                w_rs2      = 5'd0;
                w_jalr     = 1'b1;
                w_wr_class = 1'b1;
            end
            OP_LUI, OP_AUIPC: begin
                w_aluop    = (w_opcode == OP_LUI) ? 4'b0101 : 4'b0110;
                w_alusrc   = 1'b1;
                w_imm      = w_imm_u;
                w_rs1      = 5'd0;
                w_rs2      = 5'd0;
                w_wr_class = 1'b1;
            end
            default: w_illegal = 1'b1;
        endcase
        if (w_illegal) begin
            w_aluop    = 4'b1111;
            w_load     = 1'b0;
            w_store    = 1'b0;
            w_branch   = 1'b0;
            w_jal      = 1'b0;
            w_jalr     = 1'b0;
            w_wr_class = 1'b0;
        end
    end

    always_comb begin
        w_pc_src_exec = 2'd0;
        if (r_branch)
            w_pc_src_exec = doBranch ? 2'd1 : 2'd0;
        else if (r_jal)
            w_pc_src_exec = 2'd1;
        else if (r_jalr)
            w_pc_src_exec = 2'd2;
    end

    assign w_cnt_inc    = r_cnt + 16'd1;
    assign w_inst_ready = (r_state == S_IDLE) && r_ready_en;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= S_IDLE;
            r_ready_en <= 1'b0;
            r_aluop    <= 4'b1111;
            r_alusrc   <= 1'b0;
            r_funct3   <= 3'd0;
            r_funct7   <= 7'd0;
            r_imm      <= 32'd0;
            r_rs1      <= 5'd0;
            r_rs2      <= 5'd0;
            r_rd       <= 5'd0;
            r_load     <= 1'b0;
            r_store    <= 1'b0;
            r_branch   <= 1'b0;
            r_jal      <= 1'b0;
            r_jalr     <= 1'b0;
            r_regwrite <= 1'b0;
            r_illegal  <= 1'b0;
            r_pc_src   <= 2'd0;
            r_cnt      <= 16'd0;
            r_err      <= 1'b0;
        end else begin
            r_ready_en <= 1'b1;
            r_err      <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_inst_ready && inst_valid) begin
                        r_aluop    <= w_aluop;
                        r_alusrc   <= w_alusrc;
                        r_funct3   <= w_f3;
                        r_funct7   <= w_f7;
                        r_imm      <= w_imm;
                        r_rs1      <= w_rs1;
                        r_rs2      <= w_rs2;
                        r_rd       <= w_rd;
                        r_load     <= w_load;
                        r_store    <= w_store;
                        r_branch   <= w_branch;
                        r_jal      <= w_jal;
                        r_jalr     <= w_jalr;
                        r_regwrite <= w_wr_class && (w_rd != 5'd0);
                        r_illegal  <= w_illegal;
                        r_pc_src   <= 2'd0;
                        r_cnt      <= 16'd0;
                        r_state    <= S_DECODE;
                    end
                end
                S_DECODE: begin
                    if (r_illegal) begin
                        r_err   <= 1'b1;
                        r_state <= S_IDLE;
                    end else begin
                        r_state <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    r_pc_src <= w_pc_src_exec;
                    r_state  <= (r_load || r_store) ? S_MEM : S_WB;
                end
                S_MEM: begin
                    if (mem_ready) begin
                        r_state <= S_WB;
                    end else if ((TIMEOUT_L != 16'd0) && (w_cnt_inc == TIMEOUT_L)) begin
                        r_err   <= 1'b1;
                        r_state <= S_IDLE;
                    end else begin
                        r_cnt <= w_cnt_inc;
                    end
                end
                S_WB: begin
                    r_pc_src <= 2'd0;
                    r_state  <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // pc_src follows doBranch live during EXEC, then holds the sampled choice until IDLE.
    assign inst_ready = w_inst_ready;
    assign ALUOp      = (r_state == S_IDLE) ? 4'b1111 : r_aluop;
    assign ALUSrc     = r_alusrc;
    assign funct3     = r_funct3;
    assign funct7     = r_funct7;
    assign imm32      = r_imm;
    assign rs1        = r_rs1;
    assign rs2        = r_rs2;
    assign rd         = r_rd;
    assign RegWrite   = (r_state == S_WB) && r_regwrite;
    assign MemRead    = (r_state == S_MEM) && r_load;
    assign MemWrite   = (r_state == S_MEM) && r_store;
    assign MemtoReg   = (r_state == S_WB) && r_load;
    assign pc_src     = (r_state == S_EXEC) ? w_pc_src_exec : r_pc_src;
    assign instr_done = (r_state == S_WB);
    assign err        = r_err;

endmodule
